// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Initiator side of the instruction memory interface. The PC register drives
//   a combinational instruction memory; the returned instruction is captured
//   together with its address into a small FIFO that feeds decode over a
//   valid/ready handshake. Handles branch redirect (flush + reload PC) and a
//   HALT opcode that stops fetching until a redirect or reset.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   mem_pc         [7:0]  address to instruction memory (PC flop)
//   mem_instr      [23:0] instruction returned by memory, same cycle
//   redirect       load redirect_pc, flush FIFO, resume fetch
//   redirect_pc    [7:0]  new fetch address
//   out_valid      FIFO head valid
//   out_ready      decode accepts head this cycle
//   out_instr      [23:0] instruction at FIFO head (0 when empty)
//   out_pc         [7:0]  address of out_instr (0 when empty)
//   halted         high while fetching is stopped by HALT
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int         DEPTH       = 2,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  mem_pc,
  input  logic [23:0] mem_instr,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_instr,
  output logic [7:0]  out_pc,
  output logic        halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {S_FETCH, S_HALT} state_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic [23:0] instr;
  } fetch_entry_t;

  state_t          state;
  logic [7:0]      pc;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  fetch_entry_t    fifo_q [DEPTH];

  logic full, pop, push;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // When full, a simultaneous pop frees the slot, so fetch keeps streaming.
  // Redirect suppresses the push: the instruction at the old PC is stale.
  assign push      = (state == S_FETCH) && !redirect && (!full || pop);

  // mem_pc comes straight from the PC flop; out_ready never reaches it.
  assign mem_pc    = pc;
  assign out_instr = out_valid ? fifo_q[rd_ptr].instr : '0;
  assign out_pc    = out_valid ? fifo_q[rd_ptr].pc    : '0;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      pc     <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (redirect) begin
      // Flush wins over everything; a same-cycle pop was already seen by decode.
      state  <= S_FETCH;
      pc     <= redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= {pc, mem_instr};
        wr_ptr         <= wr_ptr + 1'b1;
        pc             <= pc + 8'd1;
        // HALT itself is enqueued; PC is left at halt address + 1.
        if (mem_instr[23:20] == HALT_OPCODE) state <= S_HALT;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  mem_pc;
  logic [23:0] mem_instr;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;
  logic        halt_en;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc;

  typedef struct {
    logic [7:0]  pc;
    logic [23:0] instr;
  } exp_t;
  exp_t sb[$];

  instruction_fetch_unit #(.DEPTH(2), .HALT_OPCODE(4'hF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_pc      (mem_pc),
    .mem_instr   (mem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .halted      (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: instr[k] = {1, 000, k}; optional HALT at 0x05.
  always_comb begin
    mem_instr = {4'h1, 12'h000, mem_pc};
    if (halt_en && mem_pc == 8'h05) mem_instr = 24'hF00005;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted head must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop_pc", {24'h0, out_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_pc", {24'h0, out_pc}, {24'h0, e.pc});
        chk("out_instr", {8'h0, out_instr}, {8'h0, e.instr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_base(input logic [7:0] pc);
    sb.push_back('{pc, {4'h1, 12'h000, pc}});
  endtask

  // Hold out_ready high exactly while expectations remain, so decode never
  // accepts an entry the scoreboard has no expectation for.
  task automatic drain(input int max, output int n);
    n = 0;
    out_ready = (sb.size() != 0);
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    out_ready = 1'b0; halt_en = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mem_pc", mem_pc, 0);
    tick();
    rst_n = 1'b1;

    // 1: streaming from reset, one instruction per cycle
    for (int k = 0; k < 8; k++) exp_base(8'(k));
    drain(40, cyc);
    chk("stream_cycles", cyc, 9);

    // 2: backpressure, FIFO fills and PC freezes
    do_reset();
    repeat (5) tick();
    chk("full_mem_pc", mem_pc, 8'h02);
    chk("full_valid", out_valid, 1);
    chk("full_head_pc", out_pc, 8'h00);
    for (int k = 0; k < 5; k++) exp_base(8'(k));
    drain(40, cyc);

    // 3: redirect with full FIFO flushes stale entries
    repeat (3) tick();
    chk("pre_redir_valid", out_valid, 1);
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    chk("redir_valid", out_valid, 0);
    chk("redir_mem_pc", mem_pc, 8'h40);
    exp_base(8'h40); exp_base(8'h41); exp_base(8'h42);
    drain(40, cyc);
    chk("redir_cycles", cyc, 4);

    // 4: HALT at 0x05, then redirect resumes
    halt_en = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) exp_base(8'(k));
    sb.push_back('{8'h05, 24'hF00005});
    drain(40, cyc);
    chk("halt_cycles", cyc, 7);
    repeat (3) tick();
    chk("halt_halted", halted, 1);
    chk("halt_mem_pc", mem_pc, 8'h06);
    chk("halt_drained", out_valid, 0);
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    halt_en = 1'b0;
    chk("unhalt_halted", halted, 0);
    chk("unhalt_mem_pc", mem_pc, 8'h10);
    exp_base(8'h10); exp_base(8'h11);
    drain(40, cyc);

    // 5: PC wrap FF -> 00
    redirect = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    exp_base(8'hFE); exp_base(8'hFF); exp_base(8'h00); exp_base(8'h01);
    drain(40, cyc);
    chk("wrap_cycles", cyc, 5);

    // 7: back-to-back redirects, last one wins
    redirect = 1'b1; redirect_pc = 8'h80;
    tick();
    redirect_pc = 8'h90;
    tick();
    redirect = 1'b0;
    chk("redir2_mem_pc", mem_pc, 8'h90);
    chk("redir2_valid", out_valid, 0);
    exp_base(8'h90); exp_base(8'h91);
    drain(40, cyc);

    // 6: async reset mid-stream with full FIFO
    repeat (3) tick();
    chk("prerst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_instr", out_instr, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_halted", halted, 0);
    chk("arst_mem_pc", mem_pc, 0);
    tick();
    rst_n = 1'b1;
    exp_base(8'h00); exp_base(8'h01);
    drain(40, cyc);

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
